// File: rtl/mux_monitor_pkg.sv
// Shared definitions for the multiplexed dice / traffic-light monitor.
// Holds the light phase encoding, the four legal light patterns
// ({red,amber,green}), the tracker state enum and small decode helpers.
package mux_monitor_pkg;

  localparam logic [1:0] PH_RED       = 2'd0;
  localparam logic [1:0] PH_RED_AMBER = 2'd1;
  localparam logic [1:0] PH_GREEN     = 2'd2;
  localparam logic [1:0] PH_AMBER     = 2'd3;

  localparam logic [2:0] PAT_RED       = 3'b100;
  localparam logic [2:0] PAT_RED_AMBER = 3'b110;
  localparam logic [2:0] PAT_GREEN     = 3'b001;
  localparam logic [2:0] PAT_AMBER     = 3'b010;

  typedef enum logic [2:0] {
    TRK_UNLOCKED,
    TRK_RED,
    TRK_RED_AMBER,
    TRK_GREEN,
    TRK_AMBER
  } trk_state_e;

  // Illegal patterns map to TRK_UNLOCKED, which doubles as the "not legal" flag.
  function automatic trk_state_e pat_to_state(input logic [2:0] pat);
    case (pat)
      PAT_RED:       return TRK_RED;
      PAT_RED_AMBER: return TRK_RED_AMBER;
      PAT_GREEN:     return TRK_GREEN;
      PAT_AMBER:     return TRK_AMBER;
      default:       return TRK_UNLOCKED;
    endcase
  endfunction

  function automatic logic [1:0] state_to_phase(input trk_state_e st);
    case (st)
      TRK_RED_AMBER: return PH_RED_AMBER;
      TRK_GREEN:     return PH_GREEN;
      TRK_AMBER:     return PH_AMBER;
      default:       return PH_RED;
    endcase
  endfunction

  function automatic trk_state_e next_state(input trk_state_e st);
    case (st)
      TRK_RED:       return TRK_RED_AMBER;
      TRK_RED_AMBER: return TRK_GREEN;
      TRK_GREEN:     return TRK_AMBER;
      TRK_AMBER:     return TRK_RED;
      default:       return TRK_UNLOCKED;
    endcase
  endfunction

endpackage

// File: rtl/mux_monitor_if.sv
// Bundle of the monitored stream (sel, result) and all monitor responses.
// master: stream source / observer; slave: the monitor itself.
interface mux_monitor_if #(
  parameter int ERR_W = 8
) ();
  logic             sel;
  logic [2:0]       result;
  logic [2:0]       dice_q;
  logic             dice_chg;
  logic             dice_err;
  logic [2:0]       lights_q;
  logic [1:0]       phase;
  logic             locked;
  logic             seq_err;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output sel, result,
    input  dice_q, dice_chg, dice_err, lights_q, phase, locked, seq_err, err_cnt
  );

  modport slave (
    input  sel, result,
    output dice_q, dice_chg, dice_err, lights_q, phase, locked, seq_err, err_cnt
  );
endinterface

// File: rtl/mux_monitor_tracker.sv
// light_seq_tracker: follows the traffic-light sequence on the light samples.
// Ports: clk, rst (sync, active-low), sel_i (sample is a light pattern),
// first_i (first light sample after sel rose), result_i (pattern),
// phase_o/locked_o/lights_o/seq_err_o (registered responses),
// seq_err_nxt_o (error decision for this cycle, feeds the shared counter).
//
// state         | meaning
// TRK_UNLOCKED  | not synchronised; next legal pattern sets the phase
// TRK_RED       | locked, showing 100
// TRK_RED_AMBER | locked, showing 110
// TRK_GREEN     | locked, showing 001
// TRK_AMBER     | locked, showing 010
module light_seq_tracker
  import mux_monitor_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sel_i,
  input  logic       first_i,
  input  logic [2:0] result_i,
  output logic [1:0] phase_o,
  output logic       locked_o,
  output logic [2:0] lights_o,
  output logic       seq_err_o,
  output logic       seq_err_nxt_o
);

  trk_state_e state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic       locked_q, locked_d;
  logic [2:0] lights_q, lights_d;
  logic       seq_err_q, seq_err_d;
  trk_state_e tgt;

  assign tgt = pat_to_state(result_i);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= TRK_UNLOCKED;
      phase_q   <= PH_RED;
      locked_q  <= 1'b0;
      lights_q  <= 3'b000;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      locked_q  <= locked_d;
      lights_q  <= lights_d;
      seq_err_q <= seq_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    locked_d  = locked_q;
    lights_d  = lights_q;
    seq_err_d = 1'b0;
    if (sel_i) begin
      // A fresh light stream is never order-checked against stale state.
      if (first_i || state_q == TRK_UNLOCKED) begin
        if (tgt != TRK_UNLOCKED) begin
          state_d  = tgt;
          phase_d  = state_to_phase(tgt);
          lights_d = result_i;
          locked_d = 1'b1;
        end else begin
          state_d   = TRK_UNLOCKED;
          locked_d  = 1'b0;
          seq_err_d = 1'b1;
        end
      end else if (tgt != state_q) begin
        if (tgt != TRK_UNLOCKED && tgt == next_state(state_q)) begin
          state_d  = tgt;
          phase_d  = state_to_phase(tgt);
          lights_d = result_i;
        end else begin
          // Lose sync but keep the last good phase/pattern visible.
          state_d   = TRK_UNLOCKED;
          locked_d  = 1'b0;
          seq_err_d = 1'b1;
        end
      end
    end
  end

  assign phase_o       = phase_q;
  assign locked_o      = locked_q;
  assign lights_o      = lights_q;
  assign seq_err_o     = seq_err_q;
  assign seq_err_nxt_o = seq_err_d;

endmodule

// File: rtl/mux_monitor.sv
// mux_monitor: checks a stream multiplexing dice values (sel=0) and
// traffic-light patterns (sel=1). Dice checking, the sel history and the
// saturating error counter live here; light sequencing is in light_seq_tracker.
// Ports: clk, rst (sync, active-low), bus (slave modport of mux_monitor_if).
module mux_monitor
  import mux_monitor_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  mux_monitor_if.slave bus
);

  logic             sel_prev_q;
  logic [2:0]       dice_val_q, dice_val_d;
  logic             dice_chg_q, dice_chg_d;
  logic             dice_err_q, dice_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             first_light;
  logic             seq_err_nxt;
  logic [1:0]       trk_phase;

  assign first_light = bus.sel & ~sel_prev_q;

  light_seq_tracker u_tracker (
    .clk           (clk),
    .rst           (rst),
    .sel_i         (bus.sel),
    .first_i       (first_light),
    .result_i      (bus.result),
    .phase_o       (trk_phase),
    .locked_o      (bus.locked),
    .lights_o      (bus.lights_q),
    .seq_err_o     (bus.seq_err),
    .seq_err_nxt_o (seq_err_nxt)
  );

  always_comb begin
    dice_val_d = dice_val_q;
    dice_chg_d = 1'b0;
    dice_err_d = 1'b0;
    if (!bus.sel) begin
      if (bus.result == 3'd0 || bus.result == 3'd7) begin
        dice_err_d = 1'b1;
      end else if (bus.result != dice_val_q) begin
        dice_val_d = bus.result;
        dice_chg_d = 1'b1;
      end
    end
  end

  // dice_err_d and seq_err_nxt depend on opposite sel values, so at most one
  // fires per cycle and a single increment suffices.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((dice_err_d || seq_err_nxt) && err_cnt_q != {ERR_W{1'b1}}) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_prev_q <= 1'b0;
      dice_val_q <= 3'd0;
      dice_chg_q <= 1'b0;
      dice_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      sel_prev_q <= bus.sel;
      dice_val_q <= dice_val_d;
      dice_chg_q <= dice_chg_d;
      dice_err_q <= dice_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.dice_q   = dice_val_q;
  assign bus.dice_chg = dice_chg_q;
  assign bus.dice_err = dice_err_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.phase    = (trk_phase == PH_RED) ? PH_RED : trk_phase;

endmodule
